// File: rtl/alu_command_issuer.sv
// Command issuer that drives operands onto an external ALU, pulses its flag write-enable for one
// cycle and captures the result/flags for a ready/valid response. Optional macro:
// ALU_ISSUER_BYPASS_EN lets a new command be accepted on the same edge as the response handshake.
module alu_command_issuer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FUNSEL_W = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [FUNSEL_W-1:0] ReqFunSel,
  input  logic [DATA_W-1:0]   ReqA,
  input  logic [DATA_W-1:0]   ReqB,
  input  logic                ReqWF,
  output logic [DATA_W-1:0]   AluA,
  output logic [DATA_W-1:0]   AluB,
  output logic [FUNSEL_W-1:0] AluFunSel,
  output logic                AluWF,
  input  logic [DATA_W-1:0]   AluOut,
  input  logic [3:0]          AluFlags,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [DATA_W-1:0]   RspData,
  output logic [3:0]          RspFlags
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResp} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [FUNSEL_W-1:0] alu_fun_sel_q, alu_fun_sel_d;
  logic                alu_wf_q, alu_wf_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic                req_accept;
  logic                rsp_accept;

  always_comb begin
    rsp_accept = (state_q == StResp) && RspReady;
`ifdef ALU_ISSUER_BYPASS_EN
    ReqReady   = !Reset && ((state_q == StIdle) || rsp_accept);
`else
    ReqReady   = !Reset && (state_q == StIdle);
`endif
    req_accept = ReqValid && ReqReady;

    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_fun_sel_d = alu_fun_sel_q;
    alu_wf_d      = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_flags_d   = rsp_flags_q;

    case (state_q)
      StIdle:    state_d = StIdle;
      StDrive:   state_d = StCapture;
      StCapture: begin
        // Flags were written by the ALU on the previous edge, so they are current here.
        rsp_data_d  = AluOut;
        rsp_flags_d = AluFlags;
        state_d     = StResp;
      end
      StResp:    if (rsp_accept) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Accept is only possible in IDLE, or in RESP alongside the handshake when bypass is built in.
    if (req_accept) begin
      alu_a_d       = ReqA;
      alu_b_d       = ReqB;
      alu_fun_sel_d = ReqFunSel;
      alu_wf_d      = ReqWF;
      state_d       = StDrive;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_fun_sel_q <= '0;
      alu_wf_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_fun_sel_q <= alu_fun_sel_d;
      alu_wf_q      <= alu_wf_d;
      rsp_data_q    <= rsp_data_d;
      rsp_flags_q   <= rsp_flags_d;
    end
  end

  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign AluFunSel = alu_fun_sel_q;
  assign AluWF     = alu_wf_q;
  assign RspValid  = (state_q == StResp);
  assign RspData   = rsp_data_q;
  assign RspFlags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_command_issuer.sv
// Scoreboard bench for alu_command_issuer with a small behavioural ALU (registered flags).
module tb_alu_command_issuer;
  localparam int DW = 16;
  localparam int FW = 5;
`ifdef ALU_ISSUER_BYPASS_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 4;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqWF = 1'b0;
  logic          RspReady = 1'b0;
  logic [FW-1:0] ReqFunSel = '0;
  logic [DW-1:0] ReqA = '0;
  logic [DW-1:0] ReqB = '0;
  logic          ReqReady, AluWF, RspValid;
  logic [FW-1:0] AluFunSel;
  logic [DW-1:0] AluA, AluB, AluOut, RspData;
  logic [3:0]    AluFlags, RspFlags;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  exp_flags = 4'h0;
  logic [3:0]  alu_flags_r = 4'h0;

  always #5 Clock = ~Clock;

  alu_command_issuer #(.DATA_W(DW), .FUNSEL_W(FW)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqFunSel(ReqFunSel), .ReqA(ReqA), .ReqB(ReqB), .ReqWF(ReqWF),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags), .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspFlags(RspFlags)
  );

  // Returns {Z,C,N,O,result}.
  function automatic logic [19:0] alu_f(input logic [4:0] fs, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic c, o;
    c = 1'b0;
    o = 1'b0;
    case (fs)
      5'b10100: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'b11101: begin r = {a[15], a[15:1]}; c = a[0]; end
      5'b11011: begin r = {a[14:0], 1'b0}; c = a[15]; o = a[15] ^ a[14]; end
      default:  r = a;
    endcase
    return {(r == 16'h0), c, r[15], o, r};
  endfunction

  logic [19:0] alu_res;
  assign alu_res  = alu_f(AluFunSel, AluA, AluB);
  assign AluOut   = alu_res[15:0];
  assign AluFlags = alu_flags_r;
  always @(posedge Clock) if (AluWF) alu_flags_r <= alu_res[19:16];

  // Scoreboard push on every accepted command.
  always @(posedge Clock) begin : push_blk
    logic [19:0] e;
    logic [3:0]  nf;
    if (!Reset && ReqValid && ReqReady) begin
      e  = alu_f(ReqFunSel, ReqA, ReqB);
      nf = ReqWF ? e[19:16] : exp_flags;
      exp_flags <= nf;
      exp_q.push_back({nf, e[15:0]});
    end
  end

  task automatic do_cmd(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                        input logic wf, output logic got, output int lat, output int wf_cnt,
                        output logic [15:0] data, output logic [3:0] flags);
    int n;
    @(negedge Clock);
    ReqFunSel = fs; ReqA = a; ReqB = b; ReqWF = wf; ReqValid = 1'b1;
    #1;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); #1; n++; end
    @(negedge Clock);
    ReqValid = 1'b0;
    lat = 1;
    wf_cnt = int'(AluWF);
    while (!RspValid && lat < 10) begin
      @(negedge Clock);
      lat++;
      wf_cnt += int'(AluWF);
    end
    got = RspValid; data = RspData; flags = RspFlags;
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if ({ReqReady, RspValid, AluWF, AluA, AluB, AluFunSel, RspData, RspFlags} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b wf=%b a=%h b=%h fs=%b d=%h f=%b want all 0",
               ReqReady, RspValid, AluWF, AluA, AluB, AluFunSel, RspData, RspFlags);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", ReqReady);
    end
  endtask

  task automatic test_add();
    logic got; int lat, wfc; logic [15:0] d; logic [3:0] f; logic [19:0] e;
    do_cmd(5'b10100, 16'h1234, 16'h4321, 1'b1, got, lat, wfc, d, f);
    checks++;
    if (got !== 1'b1 || lat != 3) begin
      errors++; $display("FAIL add_latency got valid=%b lat=%0d want 1/3", got, lat);
    end
    checks++;
    if ({f, d} !== {4'b0000, 16'h5555}) begin
      errors++; $display("FAIL add_result got %h/%b want 5555/0000", d, f);
    end
    checks++;
    if (wfc != 1) begin errors++; $display("FAIL add_wf_pulse got %0d want 1", wfc); end
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
    if ({f, d} !== e) begin errors++; $display("FAIL add_scoreboard got %h want %h", {f, d}, e); end
    checks++;
    if ({AluA, AluB, AluFunSel} !== {16'h1234, 16'h4321, 5'b10100}) begin
      errors++; $display("FAIL add_operand_hold got %h %h %b want 1234 4321 10100",
                         AluA, AluB, AluFunSel);
    end
  endtask

  task automatic test_asr();
    logic got; int lat, wfc; logic [15:0] d; logic [3:0] f; logic [19:0] e;
    do_cmd(5'b11101, 16'h8765, 16'h0000, 1'b1, got, lat, wfc, d, f);
    checks++;
    if (got !== 1'b1 || {f, d} !== {4'b0110, 16'hC3B2}) begin
      errors++; $display("FAIL asr_result got v=%b %h/%b want 1 C3B2/0110", got, d, f);
    end
    checks++;
    if (wfc != 1) begin errors++; $display("FAIL asr_wf_pulse got %0d want 1", wfc); end
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
    if ({f, d} !== e) begin errors++; $display("FAIL asr_scoreboard got %h want %h", {f, d}, e); end
  endtask

  task automatic test_wf0();
    logic got; int lat, wfc; logic [15:0] d; logic [3:0] f; logic [19:0] e;
    do_cmd(5'b11011, 16'h1234, 16'h0000, 1'b0, got, lat, wfc, d, f);
    checks++;
    if (got !== 1'b1 || {f, d} !== {4'b0110, 16'h2468}) begin
      errors++; $display("FAIL wf0_result got v=%b %h/%b want 1 2468/0110", got, d, f);
    end
    checks++;
    if (wfc != 0) begin errors++; $display("FAIL wf0_no_pulse got %0d want 0", wfc); end
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
    if ({f, d} !== e) begin errors++; $display("FAIL wf0_scoreboard got %h want %h", {f, d}, e); end
  endtask

  task automatic test_hold();
    int n; logic [15:0] d0; logic [3:0] f0; logic [19:0] e;
    @(negedge Clock);
    ReqFunSel = 5'b10100; ReqA = 16'h00FF; ReqB = 16'h0001; ReqWF = 1'b1; ReqValid = 1'b1;
    #1;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); #1; n++; end
    @(negedge Clock);
    ReqA = 16'hAAAA;  // second request kept valid, must be ignored while busy
    n = 0;
    while (!RspValid && n < 10) begin @(negedge Clock); n++; end
    d0 = RspData; f0 = RspFlags;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (RspValid !== 1'b1 || RspData !== d0 || RspFlags !== f0 || ReqReady !== 1'b0 ||
          AluA !== 16'h00FF) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got v=%b d=%h f=%b rdy=%b a=%h want 1 %h %b 0 00FF",
                 i, RspValid, RspData, RspFlags, ReqReady, AluA, d0, f0);
      end
      @(negedge Clock);
    end
    checks++;
    if (exp_q.size() != 1) begin
      errors++; $display("FAIL hold_ignored_req got queue %0d want 1", exp_q.size());
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;
    checks++;
    if ({f0, d0} !== {4'b0000, 16'h0100}) begin
      errors++; $display("FAIL hold_result got %h/%b want 0100/0000", d0, f0);
    end
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
    if ({f0, d0} !== e) begin errors++; $display("FAIL hold_scoreboard got %h want %h", {f0, d0}, e); end
    #1;
    checks++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
      errors++; $display("FAIL hold_release got v=%b rdy=%b want 0 1", RspValid, ReqReady);
    end
  endtask

  task automatic test_reset_abort();
    int n, seen;
    @(negedge Clock);
    ReqFunSel = 5'b11011; ReqA = 16'h4000; ReqB = 16'h0000; ReqWF = 1'b1; ReqValid = 1'b1;
    #1;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); #1; n++; end
    @(negedge Clock);
    ReqValid = 1'b0;
    checks++;
    if (AluWF !== 1'b1) begin errors++; $display("FAIL abort_drive_wf got %b want 1", AluWF); end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    checks++;
    if (ReqReady !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset got %b want 0", ReqReady); end
    @(negedge Clock);
    checks++;
    if ({RspValid, AluWF, AluA, AluB, AluFunSel, RspData, RspFlags} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got v=%b wf=%b a=%h b=%h fs=%b d=%h f=%b want all 0",
               RspValid, AluWF, AluA, AluB, AluFunSel, RspData, RspFlags);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %b want 1", ReqReady); end
    seen = 0;
    repeat (4) begin @(negedge Clock); seen += int'(RspValid) + int'(AluWF); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_response got %0d want 0", seen); end
    checks++;
    if (exp_q.size() != 1) begin
      errors++; $display("FAIL abort_queue got %0d want 1", exp_q.size());
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    int hs[$]; logic [19:0] e;
    @(negedge Clock);
    RspReady = 1'b1;
    ReqFunSel = 5'b10100; ReqA = 16'h1111; ReqB = 16'h2222; ReqWF = 1'b1; ReqValid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge Clock);
      if (cyc == 30) ReqValid = 1'b0;
      if (RspValid) begin
        hs.push_back(cyc);
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
        if ({RspFlags, RspData} !== e || e !== {4'b0000, 16'h3333}) begin
          errors++; $display("FAIL b2b_scoreboard cyc %0d got %h want %h", cyc, {RspFlags, RspData}, e);
        end
      end
    end
    RspReady = 1'b0;
    checks++;
    if (hs.size() < 5) begin errors++; $display("FAIL b2b_count got %0d want >=5", hs.size()); end
    for (int i = 1; i < hs.size(); i++) begin
      checks++;
      if (hs[i] - hs[i-1] != PERIOD) begin
        errors++; $display("FAIL b2b_period idx %0d got %0d want %0d", i, hs[i] - hs[i-1], PERIOD);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_asr();
    test_wf0();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_command_issuer.md
ALU_COMMAND_ISSUER -- requirements
Module: alu_command_issuer

Interface
REQ-001 Parameter: DATA_W, 16, operand/result width.
REQ-002 Parameter: FUNSEL_W, 5, ALU function-select width.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ReqValid  input  1  command request valid.
REQ-006 ReqReady  output  1  issuer can accept a command.
REQ-007 ReqFunSel  input  FUNSEL_W  ALU function select for the command.
REQ-008 ReqA, ReqB  input  DATA_W each  operands.
REQ-009 ReqWF  input  1  request a flag-register update.
REQ-010 AluA, AluB  output  DATA_W each  operands driven to the ALU.
REQ-011 AluFunSel  output  FUNSEL_W  function select driven to the ALU.
REQ-012 AluWF  output  1  flag write-enable driven to the ALU.
REQ-013 AluOut  input  DATA_W  ALU combinational result.
REQ-014 AluFlags  input  4  ALU registered flags, ordered {Z,C,N,O}.
REQ-015 RspValid  output  1  response valid.
REQ-016 RspReady  input  1  consumer accepts response.
REQ-017 RspData, RspFlags  output  DATA_W, 4  captured result and flags.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, CAPTURE, RESP.
REQ-019 ReqReady SHALL be 1 only in IDLE and Reset=0 (except per REQ-031).
REQ-020 IDLE: ReqValid&ReqReady at an edge SHALL register ReqA/ReqB/ReqFunSel onto AluA/AluB/AluFunSel, load AluWF=ReqWF, and go to DRIVE.
REQ-021 DRIVE: lasts exactly one cycle; AluWF SHALL be high only in this state, so the ALU flag register updates on the DRIVE->CAPTURE edge.
REQ-022 CAPTURE: AluWF=0; at the edge, AluOut->RspData and AluFlags->RspFlags SHALL be captured; go to RESP.
REQ-023 RESP: RspValid=1; RspData/RspFlags SHALL stay stable until RspValid&RspReady, then go to IDLE.
REQ-024 Latency: accept at edge N -> RspValid high in the cycle after edge N+2.
REQ-025 AluA/AluB/AluFunSel SHALL hold their last values outside DRIVE/CAPTURE; no glitching of issued operands.
REQ-026 ReqWF=0: RspFlags SHALL reflect the unchanged ALU flag register.
REQ-027 FunSel values are passed through unchecked; the issuer does no arithmetic.
REQ-028 ReqValid while not ReqReady SHALL be ignored (requester holds).

Reset
REQ-029 Reset at any edge SHALL force IDLE; AluA, AluB, AluFunSel, RspData, RspFlags = 0; AluWF = 0; RspValid = 0.
REQ-030 Reset mid-operation SHALL abort it: no response, no further AluWF pulse; ReqReady = 0 during the Reset cycle and 1 the cycle after.

Configuration
REQ-031 Macro ALU_ISSUER_BYPASS_EN: defined -> ReqReady also = RspReady in RESP; a response handshake and new command accept at the same edge go RESP->DRIVE directly (3-cycle throughput); undefined -> ReqReady only in IDLE (4-cycle throughput minimum).

Verification
REQ-032 Reset, then ReqFunSel=10100, A=1234h, B=4321h, WF=1 -> RspValid 3 edges later, RspData=5555h, RspFlags=0000.
REQ-033 FunSel=11101, A=8765h, WF=1 -> RspData=C3B2h, RspFlags {Z,C,N,O}=0110; AluWF high exactly one cycle.
REQ-034 FunSel=11011, A=1234h, WF=0 after REQ-033 -> RspData=2468h, RspFlags=0110 (unchanged).
REQ-035 RspReady held 0 for 5 cycles -> RspValid/RspData stable, ReqReady=0, second ReqValid ignored until handshake.
REQ-036 Reset asserted in CAPTURE -> next cycle IDLE, RspValid=0, all outputs 0, no response emitted.
REQ-037 With ALU_ISSUER_BYPASS_EN, RspReady=1 and ReqValid=1 continuously -> one response every 3 cycles; without it, every 4.
